// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
// No ports; imported by mix_column_word and mix_columns_engine.
package aes_pkg;

   typedef logic [7:0]   aes_byte_t;
   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_state_t;

   // Reduction term for x^8 = x^4 + x^3 + x + 1 (field polynomial 0x11B).
   localparam aes_byte_t AES_GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      MC_IDLE,
      MC_BUSY,
      MC_DONE
   } mc_state_t;

   function automatic aes_byte_t xtime(aes_byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_GF_POLY : 8'h00);
   endfunction

   function automatic aes_byte_t gf_mul2(aes_byte_t b);
      return xtime(b);
   endfunction

   function automatic aes_byte_t gf_mul3(aes_byte_t b);
      return xtime(b) ^ b;
   endfunction

   function automatic aes_byte_t gf_mul9(aes_byte_t b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic aes_byte_t gf_mulB(aes_byte_t b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic aes_byte_t gf_mulD(aes_byte_t b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic aes_byte_t gf_mulE(aes_byte_t b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns on a single 32-bit column.
// Ports:
//   col  in   32  column, row-0 byte in [31:24]
//   inv  in   1   0 = forward, 1 = inverse transform
//   res  out  32  transformed column, same byte layout
module mix_column_word
   import aes_pkg::*;
(
   input  logic [31:0] col,
   input  logic        inv,
   output logic [31:0] res
);

   aes_byte_t a0, a1, a2, a3;
   aes_byte_t f0, f1, f2, f3;
   aes_byte_t i0, i1, i2, i3;

   assign a0 = col[31:24];
   assign a1 = col[23:16];
   assign a2 = col[15:8];
   assign a3 = col[7:0];

   // Circulant rows: each output byte rotates the coefficient set by one.
   assign f0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
   assign f1 = gf_mul2(a1) ^ gf_mul3(a2) ^ a3 ^ a0;
   assign f2 = gf_mul2(a2) ^ gf_mul3(a3) ^ a0 ^ a1;
   assign f3 = gf_mul2(a3) ^ gf_mul3(a0) ^ a1 ^ a2;

   assign i0 = gf_mulE(a0) ^ gf_mulB(a1) ^ gf_mulD(a2) ^ gf_mul9(a3);
   assign i1 = gf_mulE(a1) ^ gf_mulB(a2) ^ gf_mulD(a3) ^ gf_mul9(a0);
   assign i2 = gf_mulE(a2) ^ gf_mulB(a3) ^ gf_mulD(a0) ^ gf_mul9(a1);
   assign i3 = gf_mulE(a3) ^ gf_mulB(a0) ^ gf_mulD(a1) ^ gf_mul9(a2);

   assign res = inv ? {i0, i1, i2, i3} : {f0, f1, f2, f3};

endmodule

// File: rtl/mix_columns_engine.sv
// Handshaked AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Ports:
//   clk        in   1    system clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    in_data/in_inv valid
//   in_ready   out  1    engine accepts a block this cycle
//   in_data    in   128  state, column c = [32c+31:32c]
//   in_inv     in   1    0 = MixColumns, 1 = InvMixColumns
//   out_valid  out  1    out_data holds a completed block
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  transformed state
//   busy       out  1    block in progress
//
// state   | meaning
// MC_IDLE | empty, ready for a block
// MC_BUSY | transforming one beat of columns per cycle
// MC_DONE | result presented, held until retired
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 4,
   parameter int OUT_REG        = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int NBEATS = (COLS_PER_CYCLE > 0) ? 4 / COLS_PER_CYCLE : 1;

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   mc_state_t  state_q;
   logic [1:0] beat_q;
   logic       mode_q;
   aes_state_t res_q;
   aes_state_t res_next;
   aes_state_t out_q;
   logic       accept;
   logic       last_beat;
   int         base;

   aes_word_t  col_in  [COLS_PER_CYCLE];
   aes_word_t  col_out [COLS_PER_CYCLE];

   assign in_ready  = (state_q == MC_IDLE) | ((state_q == MC_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign last_beat = (beat_q == 2'(NBEATS - 1));
   assign base      = int'(beat_q) * COLS_PER_CYCLE;

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_in[g] = res_q[32*(base+g) +: 32];
      mix_column_word u_word (
         .col (col_in[g]),
         .inv (mode_q),
         .res (col_out[g])
      );
   end

   // Results overwrite their source columns, so one buffer holds the block
   // from accept through retire.
   always_comb begin
      res_next = res_q;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         res_next[32*(base+j) +: 32] = col_out[j];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MC_IDLE;
         beat_q    <= 2'd0;
         mode_q    <= 1'b0;
         res_q     <= '0;
         out_q     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_q)
            MC_IDLE: begin
               if (accept) begin
                  res_q   <= in_data;
                  mode_q  <= in_inv;
                  beat_q  <= 2'd0;
                  busy    <= 1'b1;
                  state_q <= MC_BUSY;
               end
            end
            MC_BUSY: begin
               res_q <= res_next;
               if (last_beat) begin
                  beat_q    <= 2'd0;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state_q   <= MC_DONE;
                  if (OUT_REG != 0) begin
                     out_q <= res_next;
                  end
               end else begin
                  beat_q <= beat_q + 2'd1;
               end
            end
            MC_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     // back-to-back: retire and accept on the same edge
                     res_q   <= in_data;
                     mode_q  <= in_inv;
                     beat_q  <= 2'd0;
                     busy    <= 1'b1;
                     state_q <= MC_BUSY;
                  end else begin
                     state_q <= MC_IDLE;
                  end
               end
            end
            default: begin
               state_q   <= MC_IDLE;
               beat_q    <= 2'd0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_data = (OUT_REG != 0) ? out_q : res_q;

endmodule
